// File: rtl/ycr_arb_pkg.sv
// Shared constants and types for the core-interface round-robin arbiter and its response router.
// The arbiter and the response router both use this grant encoding.
package ycr_arb_pkg;

  localparam int unsigned YCR_TREQ     = 2;
  localparam int unsigned YCR_TREQ_DW  = $clog2(YCR_TREQ);
  localparam int unsigned YCR_RESP_DW  = 32;
  localparam int unsigned YCR_ID_DEPTH = 2;

  // Grant bus is one bit wider than the ID; the all-ones pattern means "no grant".
  typedef logic [YCR_TREQ_DW:0]   ycr_gnt_t;
  typedef logic [YCR_TREQ_DW-1:0] ycr_id_t;

  localparam ycr_gnt_t GRANTX = '1;

  // Bit positions inside the sticky err_flag vector.
  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_ORPH = 1;

endpackage

// File: rtl/ycr_id_fifo.sv
// In-order FIFO of accepted requester IDs, with an occupancy count.
// Pointers carry one extra wrap bit, so full and empty can be told apart without a separate flag.
module ycr_id_fifo
  import ycr_arb_pkg::*;
#(
  parameter  int unsigned WIDTH = YCR_TREQ_DW,
  parameter  int unsigned DEPTH = YCR_ID_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW-1:0]    cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A push while full is accepted only alongside a pop. The head is read before the edge, so
  // overwriting the slot that is being popped is safe.
  always_ff @(posedge clk) begin
    if (rstn && push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // The head is read asynchronously, so the router can steer a response in the cycle it arrives.
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cnt_o   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ycr_resp_router.sv
// Returns downstream responses to requesters in the order their requests were accepted.
// YCR_RESP_ROUTER_REG_EN: defined = registered response outputs (1-cycle latency); undefined = combinational.
module ycr_resp_router
  import ycr_arb_pkg::*;
#(
  parameter  int unsigned TREQ    = YCR_TREQ,
  parameter  int unsigned TREQ_DW = $clog2(TREQ),
  parameter  int unsigned DW      = YCR_RESP_DW,
  parameter  int unsigned DEPTH   = YCR_ID_DEPTH,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [TREQ_DW:0]   req_id,
  input  logic               req_ack,
  input  logic               lack,
  input  logic [DW-1:0]      ldata,
  input  logic               lerr,
  output logic [TREQ-1:0]    resp_ack,
  output logic [DW-1:0]      resp_data,
  output logic [TREQ-1:0]    resp_err,
  output logic               id_full,
  output logic [CW-1:0]      outst_cnt,
  output logic [1:0]         err_flag
);

  localparam logic [TREQ_DW:0] NO_GNT = {(TREQ_DW+1){1'b1}};

  logic               id_valid;
  logic               push_req;
  logic               cut_thru;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [TREQ_DW-1:0] fifo_head;
  logic               ovf_evt;
  logic               orph_evt;
  logic               route_vld;
  logic [TREQ_DW-1:0] route_id;
  logic [TREQ-1:0]    route_ack;
  logic [TREQ-1:0]    route_err;
  logic [1:0]         err_flag_q, err_flag_d;

  assign id_valid = (req_id != NO_GNT);
  assign push_req = req_ack & id_valid;
  assign fifo_pop = lack & ~fifo_empty;
  // An empty FIFO answered in the same cycle as it is loaded never stores the ID.
  assign cut_thru = lack & fifo_empty & push_req;
  // When full, a push is accepted only alongside a pop, which frees a slot on the same edge.
  assign fifo_push = push_req & ~cut_thru & (~fifo_full | fifo_pop);
  assign ovf_evt   = push_req & fifo_full & ~fifo_pop;
  assign orph_evt  = (req_ack & ~id_valid) | (lack & fifo_empty & ~push_req);

  assign route_vld = fifo_pop | cut_thru;
  assign route_id  = fifo_pop ? fifo_head : req_id[TREQ_DW-1:0];

  ycr_id_fifo #(
    .WIDTH (TREQ_DW),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (req_id[TREQ_DW-1:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (outst_cnt)
  );

  assign id_full = fifo_full;

  for (genvar gi = 0; gi < TREQ; gi++) begin : g_decode
    assign route_ack[gi] = route_vld && (route_id == TREQ_DW'(gi));
    assign route_err[gi] = route_ack[gi] & lerr;
  end

  always_comb begin
    err_flag_d           = err_flag_q;
    err_flag_d[ERR_OVF]  = err_flag_q[ERR_OVF]  | ovf_evt;
    err_flag_d[ERR_ORPH] = err_flag_q[ERR_ORPH] | orph_evt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) err_flag_q <= '0;
    else       err_flag_q <= err_flag_d;
  end

  assign err_flag = err_flag_q;

`ifdef YCR_RESP_ROUTER_REG_EN
  logic [TREQ-1:0] resp_ack_q, resp_err_q;
  logic [DW-1:0]   resp_data_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      resp_ack_q  <= '0;
      resp_err_q  <= '0;
      resp_data_q <= '0;
    end else begin
      resp_ack_q  <= route_ack;
      resp_err_q  <= route_err;
      resp_data_q <= ldata;
    end
  end

  assign resp_ack  = resp_ack_q;
  assign resp_err  = resp_err_q;
  assign resp_data = resp_data_q;
`else
  // Outputs are held at zero while reset is asserted, so that no response leaks out.
  assign resp_ack  = rstn ? route_ack : '0;
  assign resp_err  = rstn ? route_err : '0;
  assign resp_data = rstn ? ldata     : '0;
`endif

endmodule

// File: tb/tb_ycr_resp_router.sv
// Directed and random checks of ycr_resp_router (TREQ=2, DEPTH=2), in either YCR_RESP_ROUTER_REG_EN setting.
// A queue model predicts the routing; the expected responses are queued and compared when they are due.
module tb_ycr_resp_router;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_id = 2'b11;
  logic        req_ack = 1'b0;
  logic        lack = 1'b0;
  logic [31:0] ldata = '0;
  logic        lerr = 1'b0;
  logic [1:0]  resp_ack;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic        id_full;
  logic [1:0]  outst_cnt;
  logic [1:0]  err_flag;

  always #5 clk = ~clk;

  ycr_resp_router #(.TREQ(2), .TREQ_DW(1), .DW(32), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .req_id(req_id), .req_ack(req_ack), .lack(lack),
    .ldata(ldata), .lerr(lerr), .resp_ack(resp_ack), .resp_data(resp_data),
    .resp_err(resp_err), .id_full(id_full), .outst_cnt(outst_cnt), .err_flag(err_flag)
  );

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] data;
  } exp_t;

  exp_t       eq[$];
  int         mq[$];
  logic [1:0] merr;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (eq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL resp_queue observed=empty expected=entry");
    end else begin
      e = eq.pop_front();
      chk("resp_ack", {30'd0, resp_ack}, {30'd0, e.ack});
      chk("resp_err", {30'd0, resp_err}, {30'd0, e.err});
      if (e.ack != 2'b00) chk("resp_data", resp_data, e.data);
    end
  endtask

  // Reference behaviour: an in-order queue of IDs, with routing judged on the state before the edge.
  task automatic model(input logic ra, input logic [1:0] rid, input logic la,
                       input logic [31:0] ld, input logic le);
    exp_t e;
    bit   valid, cut, empty0, full0;
    int   h;
    e.ack = 2'b00; e.err = 2'b00; e.data = ld;
    valid  = ra && (rid != 2'b11);
    empty0 = (mq.size() == 0);
    full0  = (mq.size() == 2);
    cut    = 0;
    if (ra && !valid) merr[1] = 1'b1;
    if (la && !empty0) begin
      h = mq.pop_front();
      e.ack[h] = 1'b1;
      e.err[h] = le;
    end else if (la && valid) begin
      cut = 1;
      e.ack[rid[0]] = 1'b1;
      e.err[rid[0]] = le;
    end else if (la) begin
      merr[1] = 1'b1;
    end
    if (valid && !cut) begin
      if (full0 && !la) merr[0] = 1'b1;
      else mq.push_back(int'(rid[0]));
    end
    eq.push_back(e);
  endtask

  task automatic step(input logic ra, input logic [1:0] rid, input logic la,
                      input logic [31:0] ld, input logic le);
    @(negedge clk);
    req_ack = ra; req_id = rid; lack = la; ldata = ld; lerr = le;
    model(ra, rid, la, ld, le);
`ifndef YCR_RESP_ROUTER_REG_EN
    #1 check_resp();
`endif
    @(posedge clk);
    #1;
`ifdef YCR_RESP_ROUTER_REG_EN
    check_resp();
`endif
    chk("outst_cnt", {30'd0, outst_cnt}, 32'(mq.size()));
    chk("id_full", {31'd0, id_full}, {31'd0, (mq.size() == 2)});
    chk("err_flag", {30'd0, err_flag}, {30'd0, merr});
    $display("[TB] req_ack=%0d req_id=%0d lack=%0d ldata=%h lerr=%0d -> resp_ack=%b resp_err=%b cnt=%0d full=%0d err=%b",
             ra, rid, la, ld, le, resp_ack, resp_err, outst_cnt, id_full, err_flag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_ack = 1'b1; req_id = 2'b01; lack = 1'b1; ldata = 32'hDEAD_BEEF; lerr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_ack", {30'd0, resp_ack}, 32'd0);
    chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_outst_cnt", {30'd0, outst_cnt}, 32'd0);
    chk("rst_id_full", {31'd0, id_full}, 32'd0);
    chk("rst_err_flag", {30'd0, err_flag}, 32'd0);
    @(negedge clk);
    rstn = 1'b1; req_ack = 1'b0; req_id = 2'b11; lack = 1'b0; ldata = '0; lerr = 1'b0;
    mq.delete();
    eq.delete();
    merr = 2'b00;
    $display("[TB] reset released");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ra, la;
    logic [1:0] rid;
    merr = 2'b00;

    // Reset with activity on the inputs
    do_reset();

    // In-order response
    step(1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 2'd3, 1'b1, 32'hA5A5_0001, 1'b0);
    step(1'b0, 2'd3, 1'b1, 32'hA5A5_0000, 1'b0);

    // Full, then an overflowing push
    step(1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    chk("ovf_flag", {31'd0, err_flag[0]}, 32'd1);
    step(1'b0, 2'd3, 1'b1, 32'h1111_0001, 1'b1);
    step(1'b0, 2'd3, 1'b1, 32'h1111_0000, 1'b0);

    // Cut-through
    do_reset();
    step(1'b1, 2'd1, 1'b1, 32'hC0DE_0001, 1'b1);

    // Orphan lack right after reset, then an invalid ID
    do_reset();
    step(1'b0, 2'd3, 1'b1, 32'hBAD0_0000, 1'b0);
    step(1'b1, 2'd3, 1'b0, 32'h0, 1'b0);
    chk("orphan_flag", {31'd0, err_flag[1]}, 32'd1);

    // Simultaneous push and pop while full
    do_reset();
    step(1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 32'h5150_0000, 1'b0);
    step(1'b0, 2'd3, 1'b1, 32'h5150_0001, 1'b1);
    step(1'b0, 2'd3, 1'b1, 32'h5150_0002, 1'b0);

    // Random legal traffic
    for (int i = 0; i < 64; i++) begin
      la  = 1'($urandom_range(0, 1));
      ra  = 1'($urandom_range(0, 1));
      rid = 2'($urandom_range(0, 1));
      if (mq.size() == 0 && !ra) la = 1'b0;
      if (mq.size() == 2 && !la) ra = 1'b0;
      step(ra, rid, la, $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 2; i++) begin
      if (mq.size() > 0) step(1'b0, 2'd3, 1'b1, $urandom, 1'b0);
    end
    chk("final_cnt", {30'd0, outst_cnt}, 32'd0);
    chk("final_err", {30'd0, err_flag}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
